// File: rtl/proc_pkg.sv
// Shared definitions for the processor host sequencer, control unit and RAMs.
//   WORD_W        : instruction/data word width
//   ERR_BYTE_DEF  : default byte reported to the host on a run timeout
//   status_e      : encodings carried on the status bus to the control unit
//   host_state_e  : host sequencer states
package proc_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam logic [7:0]  ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DUMP = 2'b10,
    ST_ERR  = 2'b11
  } status_e;

  typedef enum logic [3:0] {
    H_LEN,
    H_HI,
    H_LO,
    H_START,
    H_RUN,
    H_RD,
    H_RDW,
    H_TXH,
    H_TXL,
    H_ERR,
    H_DONE
  } host_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/word_byte_tx.sv
// Serialises one word into two bytes, high byte first, over a valid/ready
// handshake.
//   load      : 1-cycle strobe, captures word and raises tx_valid next cycle
//   word      : word to send
//   tx_data   : byte presented to the transmitter (held until accepted)
//   tx_valid  : byte request
//   tx_ready  : transmitter accepts the byte
//   byte_ack  : a byte transfers this cycle
//   word_done : the low byte transfers this cycle
module word_byte_tx
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              byte_ack,
  output logic              word_done
);

  logic       lo_phase;
  logic [7:0] lo_byte;

  assign byte_ack  = tx_valid & tx_ready;
  assign word_done = byte_ack & lo_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      lo_phase <= 1'b0;
      lo_byte  <= '0;
    end else if (load) begin
      tx_data  <= word[15:8];
      lo_byte  <= word[7:0];
      tx_valid <= 1'b1;
      lo_phase <= 1'b0;
    end else if (byte_ack) begin
      if (!lo_phase) begin
        tx_data  <= lo_byte;
        lo_phase <= 1'b1;
      end else begin
        tx_valid <= 1'b0;
        lo_phase <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/proc_host_ctrl.sv
// Host-side sequencer: loads a program into instruction RAM from UART bytes
// (length byte, then hi/lo byte pairs), starts the control unit via status,
// waits for end_process, then streams DUMP_WORDS data RAM words back to the
// host. A run longer than TIMEOUT cycles reports ERR_BYTE and sets error.
//   rx_data/rx_valid             : received byte strobe
//   tx_data/tx_valid/tx_ready    : transmit handshake
//   iram_we/iram_addr/iram_wdata : instruction RAM write port (registered)
//   dram_rd_en/dram_addr         : data RAM read port, dram_rdata 1 cycle later
//   status                       : 00 load, 01 run, 10 dump/done, 11 error
//   end_process                  : control unit is in its end state
//   done / error                 : terminal outcome flags
module proc_host_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned IRAM_AW    = 8,
  parameter int unsigned DRAM_AW    = 8,
  parameter int unsigned DUMP_WORDS = 16,
  parameter int unsigned TIMEOUT    = 1048576,
  parameter logic [7:0]  ERR_BYTE   = ERR_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               iram_we,
  output logic [IRAM_AW-1:0] iram_addr,
  output logic [WORD_W-1:0]  iram_wdata,
  output logic               dram_rd_en,
  output logic [DRAM_AW-1:0] dram_addr,
  input  logic [WORD_W-1:0]  dram_rdata,
  output logic [1:0]         status,
  input  logic               end_process,
  output logic               done,
  output logic               error
);

  localparam int unsigned CW = max_u(IRAM_AW, 8);

  host_state_e        state, next_state;
  status_e            status_q;
  logic [7:0]         len, hi_byte;
  logic [CW-1:0]      ld_cnt;
  logic [31:0]        tmo_cnt;
  logic [DRAM_AW-1:0] dump_addr;
  logic               err_tx_valid, err_sent;
  logic [7:0]         wb_tx_data;
  logic               wb_tx_valid, wb_byte_ack, wb_word_done;
  logic               ld_last, tmo_hit, dump_last;

  assign ld_last   = (ld_cnt + 1'b1) == CW'(len);
  assign tmo_hit   = tmo_cnt == 32'(TIMEOUT - 1);
  assign dump_last = {1'b0, dump_addr} == (DRAM_AW + 1)'(DUMP_WORDS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= H_LEN;
    else        state <= next_state;
  end

  // end_process is tested before the timeout so it wins a same-cycle tie.
  always_comb begin
    next_state = state;
    unique case (state)
      H_LEN:   if (rx_valid) next_state = (rx_data == '0) ? H_START : H_HI;
      H_HI:    if (rx_valid) next_state = H_LO;
      H_LO:    if (rx_valid) next_state = ld_last ? H_START : H_HI;
      H_START: next_state = H_RUN;
      H_RUN: begin
        if (end_process)  next_state = H_RD;
        else if (tmo_hit) next_state = H_ERR;
      end
      H_RD:    next_state = H_RDW;
      H_RDW:   next_state = H_TXH;
      H_TXH:   if (wb_byte_ack) next_state = H_TXL;
      H_TXL:   if (wb_word_done) next_state = dump_last ? H_DONE : H_RD;
      H_ERR:   next_state = H_ERR;
      H_DONE:  next_state = H_DONE;
      default: next_state = H_LEN;
    endcase
  end

  always_comb begin
    status_q   = ST_LOAD;
    dram_rd_en = 1'b0;
    done       = 1'b0;
    unique case (state)
      H_START, H_RUN:            status_q = ST_RUN;
      H_RD: begin
        status_q   = ST_DUMP;
        dram_rd_en = 1'b1;
      end
      H_RDW, H_TXH, H_TXL:       status_q = ST_DUMP;
      H_DONE: begin
        status_q = ST_DUMP;
        done     = 1'b1;
      end
      H_ERR:                     status_q = ST_ERR;
      default:                   status_q = ST_LOAD;
    endcase
  end

  assign status    = status_q;
  assign dram_addr = dump_addr;
  assign error     = err_sent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len          <= '0;
      hi_byte      <= '0;
      ld_cnt       <= '0;
      iram_we      <= 1'b0;
      iram_addr    <= '0;
      iram_wdata   <= '0;
      tmo_cnt      <= '0;
      dump_addr    <= '0;
      err_tx_valid <= 1'b0;
      err_sent     <= 1'b0;
    end else begin
      iram_we <= 1'b0;
      unique case (state)
        H_LEN: if (rx_valid) begin
          len    <= rx_data;
          ld_cnt <= '0;
        end
        H_HI: if (rx_valid) hi_byte <= rx_data;
        H_LO: if (rx_valid) begin
          iram_we    <= 1'b1;
          iram_addr  <= ld_cnt[IRAM_AW-1:0];
          iram_wdata <= {hi_byte, rx_data};
          ld_cnt     <= ld_cnt + 1'b1;
        end
        H_START: tmo_cnt <= '0;
        H_RUN: begin
          if (end_process)  dump_addr    <= '0;
          else if (tmo_hit) err_tx_valid <= 1'b1;
          else              tmo_cnt      <= tmo_cnt + 1'b1;
        end
        H_TXL: if (wb_word_done && !dump_last) dump_addr <= dump_addr + 1'b1;
        H_ERR: if (err_tx_valid && tx_ready) begin
          err_tx_valid <= 1'b0;
          err_sent     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  word_byte_tx u_word_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == H_RDW),
    .word      (dram_rdata),
    .tx_data   (wb_tx_data),
    .tx_valid  (wb_tx_valid),
    .tx_ready  (tx_ready),
    .byte_ack  (wb_byte_ack),
    .word_done (wb_word_done)
  );

  // The error byte shares the transmit port; the word path is idle in ERR.
  assign tx_valid = wb_tx_valid | err_tx_valid;
  assign tx_data  = err_tx_valid ? ERR_BYTE : wb_tx_data;

endmodule

// File: tb/tb_proc_host_ctrl.sv
module tb_proc_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        iram_we;
  logic [7:0]  iram_addr;
  logic [15:0] iram_wdata;
  logic        dram_rd_en;
  logic [7:0]  dram_addr;
  logic [15:0] dram_rdata = '0;
  logic [1:0]  status;
  logic        end_process = 1'b0;
  logic        done;
  logic        error;

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;

  logic [15:0] dram_mem [0:255];
  logic [7:0]  txq[$];
  logic [7:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int unsigned n_st_run = 0;
  int unsigned n_rd = 0;
  logic        stall_mode = 1'b0;
  int unsigned stall_cnt = 0;
  logic        hold = 1'b0;
  logic [7:0]  hold_data = '0;

  proc_host_ctrl #(
    .IRAM_AW    (8),
    .DRAM_AW    (8),
    .DUMP_WORDS (2),
    .TIMEOUT    (100),
    .ERR_BYTE   (8'hEE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .iram_we     (iram_we),
    .iram_addr   (iram_addr),
    .iram_wdata  (iram_wdata),
    .dram_rd_en  (dram_rd_en),
    .dram_addr   (dram_addr),
    .dram_rdata  (dram_rdata),
    .status      (status),
    .end_process (end_process),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dram_rd_en) dram_rdata <= dram_mem[dram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transmitter model and output monitors. tx_ready is decided at the negedge
  // and the handshake it implies completes at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold      = 1'b0;
      stall_cnt = 0;
      tx_ready  = !stall_mode;
    end else begin
      if (hold) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid) begin
        if (!stall_mode) tx_ready = 1'b1;
        else if (stall_cnt == 10) begin
          tx_ready  = 1'b1;
          stall_cnt = 0;
        end else begin
          tx_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        tx_ready  = !stall_mode;
        stall_cnt = 0;
      end
      hold      = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (iram_we) begin
        wr_addr.push_back(iram_addr);
        wr_data.push_back(iram_wdata);
      end
      if (status == 2'b01) n_st_run++;
      if (dram_rd_en) n_rd++;
    end
  end

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n       = 1'b0;
    end_process = 1'b0;
    rx_valid    = 1'b0;
    #1;
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_iram_we"}, 32'(iram_we), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_rd_en"}, 32'(dram_rd_en), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_iram_addr"}, 32'(iram_addr), 32'd0);
    check({tag, "_iram_wdata"}, 32'(iram_wdata), 32'd0);
    idle(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_flag(input string tag, input int which, input int budget);
    int n = 0;
    while (((which == 0) ? done : error) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(((which == 0) ? done : error)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_tx, b_wr, b_rd, b_st, n;
    logic [7:0] prog [4];
    for (int unsigned i = 0; i < 256; i++) dram_mem[i] = '0;
    dram_mem[0] = 16'h0005;
    dram_mem[1] = 16'hFFFF;
    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'hAB; prog[3] = 8'hCD;

    @(negedge clk);
    async_reset("reset");

    // Load two words, then a 50-cycle run and a two-word dump.
    b_wr = wr_addr.size();
    b_tx = txq.size();
    b_rd = n_rd;
    send_rx(8'h02);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) idle(2);
      send_rx(prog[i]);
    end
    check("load_status_run", 32'(status), 32'h1);
    check("load_we_last", 32'(iram_we), 32'd1);
    idle(1);
    check("load_count", 32'(wr_addr.size() - b_wr), 32'd2);
    check("load_w0", {8'(wr_addr[b_wr]), wr_data[b_wr]}, 32'h00_1234);
    check("load_w1", {8'(wr_addr[b_wr+1]), wr_data[b_wr+1]}, 32'h01_ABCD);
    idle(10);
    check("run_status", 32'(status), 32'h1);
    check("run_no_tx", 32'(tx_valid), 32'd0);
    idle(38);
    end_process = 1'b1;
    wait_flag("dump_done", 0, 300);
    check("dump_count", 32'(txq.size() - b_tx), 32'd4);
    check("dump_bytes", {txb(b_tx), txb(b_tx+1), txb(b_tx+2), txb(b_tx+3)}, 32'h0005_FFFF);
    check("dump_status", 32'(status), 32'h2);
    check("dump_error", 32'(error), 32'd0);
    check("dump_reads", 32'(n_rd - b_rd), 32'd2);
    idle(5);
    check("done_hold", 32'(done), 32'd1);
    check("done_no_tx", 32'(tx_valid), 32'd0);

    // L=0 with a stalling transmitter.
    async_reset("reset2");
    dram_mem[0] = 16'hA55A;
    dram_mem[1] = 16'h0102;
    stall_mode = 1'b1;
    b_wr = wr_addr.size();
    b_tx = txq.size();
    send_rx(8'h00);
    check("l0_status_run", 32'(status), 32'h1);
    check("l0_no_we", 32'(iram_we), 32'd0);
    idle(5);
    end_process = 1'b1;
    wait_flag("stall_done", 0, 400);
    check("stall_count", 32'(txq.size() - b_tx), 32'd4);
    check("stall_bytes", {txb(b_tx), txb(b_tx+1), txb(b_tx+2), txb(b_tx+3)}, 32'hA55A_0102);
    check("l0_wr_count", 32'(wr_addr.size() - b_wr), 32'd0);
    stall_mode = 1'b0;

    // Timeout: end_process never rises.
    async_reset("reset3");
    b_tx = txq.size();
    b_st = n_st_run;
    send_rx(8'h00);
    wait_flag("tmo_error", 1, 300);
    check("tmo_run_cycles", 32'(n_st_run - b_st), 32'd101);
    check("tmo_count", 32'(txq.size() - b_tx), 32'd1);
    check("tmo_byte", 32'(txb(b_tx)), 32'hEE);
    check("tmo_status", 32'(status), 32'h3);
    check("tmo_done", 32'(done), 32'd0);
    idle(5);
    check("tmo_no_tx", 32'(tx_valid), 32'd0);

    // Reset right after a load write, while iram_we is high.
    async_reset("reset4");
    b_wr = wr_addr.size();
    send_rx(8'h03);
    send_rx(8'h11);
    send_rx(8'h22);
    check("mid_we_high", 32'(iram_we), 32'd1);
    async_reset("mid_load_rst");
    idle(20);
    check("mid_wr_count", 32'(wr_addr.size() - b_wr), 32'd1);
    check("mid_status", 32'(status), 32'h0);

    // Reset while the low byte is stalled in TXL.
    b_tx = txq.size();
    stall_mode  = 1'b1;
    end_process = 1'b1;
    send_rx(8'h00);
    n = 0;
    while (txq.size() < b_tx + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("txl_hi_sent", 32'(txq.size() - b_tx), 32'd1);
    idle(3);
    check("txl_valid", 32'(tx_valid), 32'd1);
    check("txl_data", 32'(tx_data), 32'h5A);
    async_reset("txl_rst");
    stall_mode = 1'b0;
    idle(20);
    check("txl_tx_count", 32'(txq.size() - b_tx), 32'd1);
    check("txl_after_valid", 32'(tx_valid), 32'd0);
    check("txl_after_status", 32'(status), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/proc_host_ctrl.md
# proc_host_ctrl

Host-side sequencer for the processor's start/end handshake, sitting between the UART byte link and the processor core. It loads a program into instruction RAM from received bytes and drives `status` to start the control unit. It then waits for `end_process` and streams a block of data RAM back to the host as bytes. It is the opposite end of the `status`/`end_process` interface that the control unit consumes and produces.

## Interface
- `IRAM_AW`, 8: instruction RAM address width.
- `DRAM_AW`, 8: data RAM address width.
- `DUMP_WORDS`, 16: data RAM words returned after a run, read from address 0 upward; range 1..2^DRAM_AW.
- `TIMEOUT`, 1048576: maximum cycles allowed in RUN before an error is declared.
- `ERR_BYTE`, 8'hEE: byte sent to the host on timeout.

Ports (clock and reset first):
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe marking `rx_data` valid.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: transmit request.
- `tx_ready` in 1: transmitter accepts the byte.
- `iram_we` out 1: instruction RAM write strobe.
- `iram_addr` out IRAM_AW: instruction RAM write address.
- `iram_wdata` out 16: instruction word to write.
- `dram_rd_en` out 1: data RAM read strobe.
- `dram_addr` out DRAM_AW: data RAM read address.
- `dram_rdata` in 16: data RAM read data, valid 1 cycle after `dram_rd_en`.
- `status` out 2: 00 = loading, 01 = start/run, 10 = dumping/done, 11 = error.
- `end_process` in 1: high while the control unit sits in its end state.
- `done` out 1: sequence complete, error-free.
- `error` out 1: RUN timed out.

## Operation
States: LEN, HI, LO, START, RUN, RD, RDW, TXH, TXL, ERR, DONE.

- **LEN:** on `rx_valid`, latch byte L into `len`.
  - L=0: go to START; instruction RAM is left as is.
  - Otherwise clear the word counter and go to HI.
- **HI:** on `rx_valid`, latch the high byte; go to LO.
- **LO:** on `rx_valid`:
  - `iram_wdata` = {hi, rx_data}, `iram_addr` = counter, `iram_we` pulses for 1 cycle.
  - Counter increments. If counter+1 == L, go to START; otherwise go back to HI.
- **START:** `status` = 01; clear the timeout counter; go to RUN.
- **RUN:** `status` holds 01; the timeout counter increments each cycle.
  - `end_process` = 1: clear the dump address and go to RD.
  - Otherwise, when the counter reaches TIMEOUT-1: go to ERR.
- **RD:** `dram_rd_en` pulses with `dram_addr` = dump address; go to RDW.
- **RDW:** capture `dram_rdata` into the word register; go to TXH.
- **TXH:** `tx_data` = word[15:8], `tx_valid` = 1. On `tx_ready`, go to TXL.
- **TXL:** `tx_data` = word[7:0], `tx_valid` = 1. On `tx_ready`:
  - If the dump address == DUMP_WORDS-1, go to DONE.
  - Otherwise increment the dump address and go to RD.
- **DONE:** `status` = 10, `done` = 1. Terminal until reset, because the control unit stays in its end state.
- **ERR:** `status` = 11; send ERR_BYTE once with the valid/ready handshake; then `error` = 1. Terminal until reset.

## Timing
- Reset values: all outputs 0, state LEN, all counters 0.
- An `rx_valid` arriving in any state other than LEN/HI/LO is dropped.
- The `iram_we` pulse occurs in the cycle after the LO byte strobe (registered outputs).
- `status` = 01 appears 1 cycle after the final LO write; the control unit samples it in its idle state.
- `end_process` arrives registered, 1 cycle after the control unit enters its end state. The RUN→RD decision is made on the first cycle it is seen high.
- If `end_process` and timeout occur in the same cycle, `end_process` wins.
- Once asserted, `tx_valid` stays high and `tx_data` stays stable until `tx_ready`; a byte transfers only on a cycle where both are high.
- Per-word dump cost: 2 cycles (RD, RDW) plus the two handshakes. Minimum is 4 cycles per word when `tx_ready` is tied high.
- Load counter wrap: L=255 writes addresses 0..254. Counter width is max(IRAM_AW, 8).
- An asynchronous `rst_n` assertion in any state returns the block to LEN immediately and drops any pending `tx_valid`/`iram_we`.

## Structure
- Shared package `proc_pkg` holds:
  - status encodings (ST_LOAD, ST_RUN, ST_DUMP, ST_ERR);
  - the host state enum;
  - the ERR_BYTE default;
  - the 16-bit word width constant, also used by the control unit and the RAMs.
- One sub-module, `word_byte_tx`: 16-bit word to two bytes, high byte first, over the valid/ready handshake, with a `word_done` pulse. Implements the TXH/TXL states.

## Test plan
- Load L=2 with bytes 12 34 AB CD: expect writes [0]=1234 and [1]=ABCD, then `status` = 01.
- Model `end_process` high 50 cycles after start; DUMP_WORDS=2; RAM[0]=0005, RAM[1]=FFFF: expect tx bytes 00 05 FF FF, then `done` = 1 and `status` = 10.
- With `tx_ready` low for 10 cycles on each byte: `tx_data` holds stable; byte order and count are unchanged.
- TIMEOUT=100 with `end_process` never asserted: after 100 RUN cycles expect tx byte EE, `error` = 1, `status` = 11.
- L=0: no `iram_we`; `status` = 01 in the next cycle.
- `rst_n` pulsed low midway through the HI/LO load and again during TXL: all outputs return to 0, state LEN, no further `iram_we` or `tx_valid`.
